// File: rtl/egress_arbiter.sv
// Per-egress-port packet scheduler: packet-granular round-robin over four
// AXIS ingress ports whose tdest selects this port, with a beat mux and tready return.
module egress_arbiter #(
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [4*DATA_W-1:0] in_tdata,
    input  logic [3:0]          in_tvalid,
    input  logic [3:0]          in_tlast,
    input  logic [7:0]          in_tdest,
    output logic [3:0]          in_tready,
    output logic [DATA_W-1:0]   out_tdata,
    output logic                out_tvalid,
    output logic                out_tlast,
    input  logic                out_tready,
    output logic [3:0]          grant,
    output logic                busy,
    output logic [CNT_W-1:0]    pkt_count
);

    localparam logic [1:0] PID = 2'(PORT_ID);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nx;
    logic [1:0]       gsel, gsel_nx;
    logic [1:0]       last, last_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       req;
    logic [1:0]       pick;
    logic [1:0]       cand;
    logic             found;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            req[i] = in_tvalid[i] && (in_tdest[2*i +: 2] == PID);
        end
    end

    // Search starts one past the last served port, so the previous winner goes last.
    always_comb begin
        pick  = gsel;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        gsel_nx    = gsel;
        last_nx    = last;
        cnt_nx     = pkt_count;
        grant      = '0;
        busy       = 1'b0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        out_tdata  = '0;
        in_tready  = '0;
        case (state)
            IDLE: begin
                if (enable && (|req)) begin
                    gsel_nx  = pick;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                grant[gsel]     = 1'b1;
                busy            = 1'b1;
                out_tvalid      = in_tvalid[gsel];
                out_tlast       = in_tlast[gsel];
                out_tdata       = in_tdata[gsel*DATA_W +: DATA_W];
                in_tready[gsel] = out_tready;
                if (out_tvalid && out_tready && out_tlast) begin
                    state_nx = IDLE;
                    last_nx  = gsel;
                    cnt_nx   = pkt_count + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gsel      <= '0;
            last      <= 2'd3;
            pkt_count <= '0;
        end else begin
            state     <= state_nx;
            gsel      <= gsel_nx;
            last      <= last_nx;
            pkt_count <= cnt_nx;
        end
    end

endmodule

// File: doc/egress_arbiter.md
Name: egress_arbiter

Overview:
- Per-egress-port packet scheduler for the 4x4 packet switch; the switch instantiates one per egress port (`NUM_EGRESS_PORTS instances).
- Shares one egress AXIS port among the 4 ingress ports whose tdest selects it, using packet-granular round-robin.
- Muxes the granted ingress beat stream onto the egress port and returns per-ingress tready contributions; the switch ORs these across instances.
- Gated by that port's bit of the switch's egress_mask register.

Parameters:
- PORT_ID, 0: index of the egress port served; ingress requests when tdest == PORT_ID.
- DATA_W, 16: AXIS tdata width.
- CNT_W, 16: width of the forwarded-packet counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- enable  in  1  egress_mask bit for this port
- in_tdata  in  4*DATA_W  ingress tdata, port i at [i*DATA_W +: DATA_W]
- in_tvalid  in  4  ingress tvalid per port
- in_tlast  in  4  ingress tlast per port
- in_tdest  in  8  ingress tdest, port i at [2i +: 2]
- in_tready  out  4  ingress tready contribution per port
- out_tdata  out  DATA_W  egress tdata
- out_tvalid  out  1  egress tvalid
- out_tlast  out  1  egress tlast
- out_tready  in  1  egress tready
- grant  out  4  one-hot current grant, 0 when idle
- busy  out  1  high in state GRANT
- pkt_count  out  CNT_W  packets forwarded (tlast handshakes), wraps

Behaviour:
- req[i] = in_tvalid[i] && (in_tdest[2i +: 2] == PORT_ID).
- Registers:
  - state (IDLE/GRANT)
  - gsel (2b)
  - last (2b)
  - pkt_count
- Reset (async, any time, including mid-packet):
  - state = IDLE, gsel = 0, last = 3 (port 0 has first priority), pkt_count = 0.
  - Outputs: grant = 0, busy = 0, out_tvalid = 0, out_tlast = 0, out_tdata = 0, in_tready = 0.
  - No partial-packet recovery: the upstream source is also reset.
- IDLE:
  - All outputs at their reset values.
  - If enable && |req: gsel <= first i with req[i], searching last+1, last+2, ... mod 4; state <= GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - grant = 1 << gsel, busy = 1.
  - out_tvalid = in_tvalid[gsel]; out_tdata and out_tlast are muxed from gsel.
  - in_tready[gsel] = out_tready; all other in_tready bits are 0.
  - out_tdata and out_tlast are don't-care when out_tvalid = 0; drive the muxed value anyway.
  - Beat handshake = out_tvalid && out_tready.
  - Handshake with out_tlast = 1: state <= IDLE, last <= gsel, pkt_count <= pkt_count + 1 (wraps at 2^CNT_W).
- Latency:
  - Request in IDLE to first egress beat presented: 1 cycle (the grant registers at the edge).
  - One dead IDLE cycle between consecutive packets on this egress port. No back-to-back grant in the tlast cycle.
- tdest is sampled only for arbitration. A tdest change mid-packet on the granted port does not affect routing.
- Granted port tvalid low mid-packet: hold the grant, out_tvalid = 0 (bubble). No timeout.
- enable deasserted in GRANT: finish the current packet; no new grant while enable = 0.
- enable deasserted in IDLE: requests are ignored and in_tready stays 0 (backpressure, no drop).
- Simultaneous requests: only the round-robin winner is granted; losers see in_tready = 0 until granted.
- Fairness: with 4 continuous requesters, grants rotate 0, 1, 2, 3, 0, ...
- Single-beat packet (tlast on the first beat): valid; GRANT lasts 1 cycle if out_tready = 1.
- No combinational path from in_tvalid or in_tdest to grant. in_tready depends combinationally only on gsel (registered) and out_tready.

Test Plan:
- Reset, then port 2 sends 3 beats (0xA001, 0xA002, 0xA003 with tlast) to PORT_ID = 1, out_tready = 1 -> first out beat 1 cycle after tvalid; out_tdata sequence matches; grant = 0100 during the packet; pkt_count = 1; then IDLE.
- All 4 ports request continuously with 2-beat packets -> grant order 0001, 0010, 0100, 1000, 0001; one idle cycle between packets; pkt_count = 5 after 5 packets.
- out_tready toggles 1, 0, 1, 0 mid-packet from port 0 -> no beat lost or duplicated; in_tready[0] mirrors out_tready; other in_tready bits stay 0.
- enable = 0 with port 3 requesting -> grant = 0 and in_tready = 0 for 10 cycles; set enable = 1 -> port 3 granted on the next edge. Drop enable mid-packet -> packet completes, then no further grant.
- Port 1 changes tdest mid-packet, and port 0 requests with tdest ≠ PORT_ID -> packet 1 completes on this port; port 0 is never granted.
- Assert reset mid-packet (between clock edges) -> outputs go to reset values immediately; after release, port 0 wins a 4-way tie.
